// File: rtl/uncrop_pad.sv
// Re-embeds a raster-ordered IN_ROWS x IN_COLS window at (Y_1, X_1) inside an
// OUT_ROWS x OUT_COLS frame and fills every other position with PAD_VALUE.
module uncrop_pad #(
    parameter int PIXEL_BIT_WIDTH = 16,
    parameter int IN_ROWS         = 48,
    parameter int IN_COLS         = 48,
    parameter int OUT_ROWS        = 100,
    parameter int OUT_COLS        = 160,
    parameter int Y_1             = 10,
    parameter int X_1             = 10,
    parameter logic [PIXEL_BIT_WIDTH-1:0] PAD_VALUE = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [PIXEL_BIT_WIDTH-1:0] pixel_in,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [PIXEL_BIT_WIDTH-1:0] pixel_out,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_last
);
    localparam int RW = (OUT_ROWS > 1) ? $clog2(OUT_ROWS) : 1;
    localparam int CW = (OUT_COLS > 1) ? $clog2(OUT_COLS) : 1;
    localparam logic [RW-1:0] ROW_LAST = RW'(OUT_ROWS - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(OUT_COLS - 1);

    // Position of the next pixel to be produced.
    logic [RW-1:0] row;
    logic [CW-1:0] col;

    int   row_i, col_i;
    logic in_win, slot_free, load, at_col_end, at_last;

    always_comb begin
        row_i      = int'(row);
        col_i      = int'(col);
        // Signed int compares keep the window test well-formed when Y_1/X_1 are 0.
        in_win     = (row_i >= Y_1) && (row_i < Y_1 + IN_ROWS) &&
                     (col_i >= X_1) && (col_i < X_1 + IN_COLS);
        slot_free  = !out_valid || out_ready;
        load       = slot_free && (!in_win || in_valid);
        at_col_end = (col == COL_LAST);
        at_last    = at_col_end && (row == ROW_LAST);
        in_ready   = in_win && slot_free;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            row       <= '0;
            col       <= '0;
            pixel_out <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else if (load) begin
            pixel_out <= in_win ? pixel_in : PAD_VALUE;
            out_valid <= 1'b1;
            out_last  <= at_last;
            if (at_col_end) begin
                col <= '0;
                row <= at_last ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end else if (slot_free) begin
            // Drained while waiting on a window pixel.
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end
    end
endmodule
